// File: rtl/gray_byte_packer_pkg.sv
// gray_byte_packer_pkg
// Purpose: shared IEEE-754 single-precision field widths and constants for the
//          gray-to-byte packer, plus the last-word byte-keep helper.
// Contents: FLT_* field widths and constants, U8_SCALE, keep_mask().
package gray_byte_packer_pkg;

   localparam int          FLT_EXP_W = 8;
   localparam int          FLT_MAN_W = 23;
   localparam int          FLT_BIAS  = 127;
   localparam logic [31:0] FLT_ONE   = 32'h3F80_0000;
   localparam int          U8_SCALE  = 255;

   // Keep mask for a word whose final byte sits at index k: bits [k:0] set.
   function automatic logic [3:0] keep_mask(input logic [1:0] k);
      case (k)
         2'd0:    keep_mask = 4'b0001;
         2'd1:    keep_mask = 4'b0011;
         2'd2:    keep_mask = 4'b0111;
         default: keep_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/gray_byte_packer_float_to_u8.sv
// float_to_u8
// Purpose: purely combinational IEEE-754 single -> 8-bit gray conversion.
//          Negative, zero, denormal and NaN give 0; values >= 1.0 and +Inf
//          give 255; otherwise floor(x*255 + 0.5), computed exactly.
// Ports:   gray_i [31:0]  float input
//          byte_o [7:0]   converted pixel
module float_to_u8
   import gray_byte_packer_pkg::*;
(
   input  logic [31:0] gray_i,
   output logic [7:0]  byte_o
);

   logic                 sign;
   logic [FLT_EXP_W-1:0] expo;
   logic [FLT_MAN_W-1:0] man;
   logic [FLT_MAN_W:0]   sig;
   logic [31:0]          prod;
   logic [7:0]           shift;

   assign sign  = gray_i[31];
   assign expo  = gray_i[30:23];
   assign man   = gray_i[22:0];
   assign sig   = {1'b1, man};
   // sig*255 fits in 32 bits; the value is prod * 2^-shift with
   // shift = bias + mantissa width - exponent (24..149 for 0 < x < 1).
   assign prod  = 32'(sig) * 32'(U8_SCALE);
   assign shift = 8'(FLT_BIAS + FLT_MAN_W) - expo;

   always_comb begin
      byte_o = 8'd0;
      if (sign || (expo == '0)) begin
         byte_o = 8'd0;
      end else if ((&expo) && (man != '0)) begin
         byte_o = 8'd0;
      end else if (gray_i[30:0] >= FLT_ONE[30:0]) begin
         byte_o = 8'hFF;
      end else if (shift > 8'd33) begin
         // prod < 2^32 <= half-LSB, so the rounded result is 0.
         byte_o = 8'd0;
      end else begin
         // Add one half-LSB then truncate: round-half-up of prod / 2^shift.
         byte_o = 8'(({2'b00, prod} + (34'd1 << (shift - 8'd1))) >> shift);
      end
   end

endmodule

// File: rtl/gray_byte_packer.sv
// gray_byte_packer
// Purpose: converts a stream of float gray pixels to bytes and packs four per
//          32-bit word (first pixel in [7:0]); a frame's last pixel flushes a
//          partial word with a matching keep mask. One-deep output register.
// Ports:   clk, rst (sync, active high)
//          gray_in[31:0], in_valid, in_last, in_ready    input stream
//          out_data[31:0], out_keep[3:0], out_last,
//          out_valid, out_ready                          output stream
//          frame_pixels[15:0]  pixels accepted in current frame (saturating)
module gray_byte_packer
   import gray_byte_packer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] gray_in,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] frame_pixels
);

   logic [7:0]  px_byte;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] acc_q, acc_d, data_q, data_d, word_now;
   logic [3:0]  keep_q, keep_d;
   logic        vld_q, vld_d, last_q, last_d, clr_q, clr_d;
   logic [15:0] frame_q, frame_d, frame_base;
   logic        in_fire, out_fire;

   float_to_u8 u_cvt (
      .gray_i (gray_in),
      .byte_o (px_byte)
   );

   assign in_ready = ~(vld_q & ~out_ready);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = vld_q & out_ready;
   // Bytes above idx are always zero in acc_q, so OR-ing places the new byte.
   assign word_now = acc_q | ({24'd0, px_byte} << {idx_q, 3'b000});
   // The count clears the cycle after an in_last transfer, so a pixel accepted
   // on that cycle starts the new frame at 1.
   assign frame_base = clr_q ? 16'd0 : frame_q;

   always_comb begin
      idx_d   = idx_q;
      acc_d   = acc_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      vld_d   = vld_q;
      frame_d = frame_base;
      clr_d   = in_fire & in_last;
      if (out_fire) vld_d = 1'b0;
      if (in_fire) begin
         if (frame_base != 16'hFFFF) frame_d = frame_base + 16'd1;
         if ((idx_q == 2'd3) || in_last) begin
            // in_ready guarantees the output slot is free or draining now.
            data_d = word_now;
            keep_d = keep_mask(idx_q);
            last_d = in_last;
            vld_d  = 1'b1;
            acc_d  = 32'd0;
            idx_d  = 2'd0;
         end else begin
            acc_d = word_now;
            idx_d = idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= 2'd0;
         acc_q   <= 32'd0;
         data_q  <= 32'd0;
         keep_q  <= 4'd0;
         last_q  <= 1'b0;
         vld_q   <= 1'b0;
         frame_q <= 16'd0;
         clr_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
         frame_q <= frame_d;
         clr_q   <= clr_d;
      end
   end

   assign out_data     = data_q;
   assign out_keep     = keep_q;
   assign out_last     = last_q;
   assign out_valid    = vld_q;
   assign frame_pixels = frame_q;

endmodule

// File: tb/tb_gray_byte_packer.sv
module tb_gray_byte_packer;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_last, out_ready;
   logic [31:0] gray_in;
   logic        in_ready, out_last, out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic [15:0] frame_pixels;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gray_byte_packer dut (
      .clk          (clk),
      .rst          (rst),
      .gray_in      (gray_in),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_keep     (out_keep),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .frame_pixels (frame_pixels)
   );

   typedef struct {
      logic [31:0] g;
      logic        last;
      logic        done;
      logic [31:0] w;
      logic [3:0]  k;
   } vec_t;

   vec_t tbl[22];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] g, input logic l);
      in_valid = 1'b1;
      gray_in  = g;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int exp_frame;
      logic exp_clr;

      //         gray          last  done  word          keep
      tbl[0]  = '{32'h00000000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[1]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[2]  = '{32'h3F000000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[3]  = '{32'h3F800000, 1'b1, 1'b1, 32'hFF80FF00, 4'hF};
      tbl[4]  = '{32'hBE800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[5]  = '{32'h7FC00000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[6]  = '{32'h40000000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[7]  = '{32'h3B808081, 1'b0, 1'b1, 32'h01FF0000, 4'hF};
      tbl[8]  = '{32'h3E800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[9]  = '{32'h7F800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[10] = '{32'h80000000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[11] = '{32'h00400000, 1'b0, 1'b1, 32'h0000FF40, 4'hF};
      tbl[12] = '{32'h3F7FFFFF, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[13] = '{32'h3C000000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[14] = '{32'h3B000000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[15] = '{32'h3B800000, 1'b0, 1'b1, 32'h010002FF, 4'hF};
      tbl[16] = '{32'h3F800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[17] = '{32'h3F800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[18] = '{32'h3F800000, 1'b1, 1'b1, 32'h00FFFFFF, 4'h7};
      tbl[19] = '{32'h3F000000, 1'b1, 1'b1, 32'h00000080, 4'h1};
      tbl[20] = '{32'h3E800000, 1'b0, 1'b0, 32'h0,        4'h0};
      tbl[21] = '{32'h3F800000, 1'b1, 1'b1, 32'h0000FF40, 4'h3};

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; gray_in = 32'h0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data",  out_data, 32'd0);
      chk("rst_keep",  {28'd0, out_keep}, 32'd0);
      chk("rst_last",  {31'd0, out_last}, 32'd0);
      chk("rst_frame", {16'd0, frame_pixels}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // Table: continuous stream with out_ready held high.
      exp_frame = 0; exp_clr = 1'b0;
      for (int i = 0; i < 22; i++) begin
         push(tbl[i].g, tbl[i].last);
         exp_frame = (exp_clr ? 0 : exp_frame) + 1;
         exp_clr   = tbl[i].last;
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].done});
         if (tbl[i].done) begin
            chk($sformatf("v%0d_data", i), out_data, tbl[i].w);
            chk($sformatf("v%0d_keep", i), {28'd0, out_keep}, {28'd0, tbl[i].k});
            chk($sformatf("v%0d_last", i), {31'd0, out_last}, {31'd0, tbl[i].last});
         end
         chk($sformatf("v%0d_frame", i), {16'd0, frame_pixels}, exp_frame);
      end
      tick();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_frame_clr", {16'd0, frame_pixels}, 32'd0);

      // Backpressure: word stalls, inputs blocked, then release during a
      // completing transfer.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'h3F800000, 1'b0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data",  out_data, 32'hFFFFFFFF);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; gray_in = 32'h3F800000; in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp_hold%0d_ready", i), {31'd0, in_ready}, 32'd0);
         chk($sformatf("bp_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp_hold%0d_data", i), out_data, 32'hFFFFFFFF);
         chk($sformatf("bp_hold%0d_frame", i), {16'd0, frame_pixels}, 32'd4);
      end
      out_ready = 1'b1; gray_in = 32'h3F000000; in_last = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_data",  out_data, 32'h00000080);
      chk("b2b_keep",  {28'd0, out_keep}, 32'h1);
      chk("b2b_last",  {31'd0, out_last}, 32'd1);
      chk("b2b_frame", {16'd0, frame_pixels}, 32'd5);
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_frame", {16'd0, frame_pixels}, 32'd0);

      // Reset mid-word discards the partial bytes.
      push(32'h3F800000, 1'b0);
      push(32'h3F800000, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_frame", {16'd0, frame_pixels}, 32'd0);
      chk("mrst_ready", {31'd0, in_ready}, 32'd1);
      push(32'h3E800000, 1'b0);
      push(32'h3F000000, 1'b0);
      push(32'h3B800000, 1'b0);
      chk("mrst_partial_valid", {31'd0, out_valid}, 32'd0);
      push(32'h3C000000, 1'b0);
      chk("mrst_word_valid", {31'd0, out_valid}, 32'd1);
      chk("mrst_word_data",  out_data, 32'h02018040);
      chk("mrst_word_keep",  {28'd0, out_keep}, 32'hF);
      chk("mrst_word_last",  {31'd0, out_last}, 32'd0);
      chk("mrst_frame4",     {16'd0, frame_pixels}, 32'd4);
      tick();
      chk("mrst_end_valid", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
